// File: rtl/apb_cmd_pkg.sv
// -----------------------------------------------------------------------------
// apb_cmd_pkg
// Shared definitions for the APB command master: FSM state encoding, default
// widths, the CoreUARTapb register map and STATUS bit positions, and a helper
// that sizes the wait counter.
// No ports (package).
// -----------------------------------------------------------------------------
package apb_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int DEF_ADDR_WIDTH     = 5;
    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_NUM_SLAVES     = 2;
    localparam int DEF_SLV_IDX_WIDTH  = 4;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    // CoreUARTapb register offsets
    localparam logic [4:0] UART_TXDATA = 5'h00;
    localparam logic [4:0] UART_RXDATA = 5'h04;
    localparam logic [4:0] UART_CTRL1  = 5'h08;
    localparam logic [4:0] UART_CTRL2  = 5'h0C;
    localparam logic [4:0] UART_STATUS = 5'h10;

    // CoreUARTapb STATUS register bit positions
    localparam int STAT_TXRDY      = 0;
    localparam int STAT_RXRDY      = 1;
    localparam int STAT_PARITY_ERR = 2;
    localparam int STAT_OVERFLOW   = 3;

    // Width able to hold 0..limit; never narrower than one bit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// -----------------------------------------------------------------------------
// apb_cmd_master_if
// Bundles the command/response handshake and the shared APB3 bus of the
// command master.
//   master modport : view of apb_cmd_master (takes commands, drives APB).
//   slave  modport : view of everything opposite it (command source plus the
//                    externally muxed APB slave return path).
// Signals:
//   cmd_valid/cmd_ready/cmd_write/cmd_slv/cmd_addr/cmd_wdata : command
//   rsp_valid/rsp_rdata/rsp_err/rsp_timeout                  : response
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA                         : APB request
//   PRDATA/PREADY/PSLVERR                                    : APB return
// -----------------------------------------------------------------------------
interface apb_cmd_master_if
    import apb_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int NUM_SLAVES    = DEF_NUM_SLAVES,
    parameter int SLV_IDX_WIDTH = DEF_SLV_IDX_WIDTH
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_write;
    logic [SLV_IDX_WIDTH-1:0] cmd_slv;
    logic [ADDR_WIDTH-1:0]    cmd_addr;
    logic [DATA_WIDTH-1:0]    cmd_wdata;

    logic                     rsp_valid;
    logic [DATA_WIDTH-1:0]    rsp_rdata;
    logic                     rsp_err;
    logic                     rsp_timeout;

    logic [NUM_SLAVES-1:0]    PSEL;
    logic                     PENABLE;
    logic                     PWRITE;
    logic [ADDR_WIDTH-1:0]    PADDR;
    logic [DATA_WIDTH-1:0]    PWDATA;
    logic [DATA_WIDTH-1:0]    PRDATA;
    logic                     PREADY;
    logic                     PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_slv, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_slv, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_wait_timer.sv
// -----------------------------------------------------------------------------
// apb_wait_timer
// Saturating counter of APB wait-state cycles.
//   i_clk     : clock
//   i_rst     : asynchronous active-high reset
//   i_clr     : clear count (priority over i_en)
//   i_en      : count this cycle (ACCESS with PREADY low)
//   o_expired : this counting cycle brings the count to TIMEOUT_CYCLES
// TIMEOUT_CYCLES = 0 disables expiry; the counter then never moves.
// -----------------------------------------------------------------------------
module apb_wait_timer
    import apb_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int               CNT_W   = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Expiry is flagged on the cycle whose increment reaches the limit, so
    // the FSM can leave ACCESS on that same edge.
    generate
        if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
            assign o_expired = 1'b0;
        end else begin : g_timeout
            assign o_expired = i_en && (r_cnt >= (CNT_MAX - 1'b1));
        end
    endgenerate

endmodule

// File: rtl/apb_cmd_master.sv
// -----------------------------------------------------------------------------
// apb_cmd_master
// Hardware APB3 initiator: turns single command/response handshakes into APB
// read/write transfers to one of NUM_SLAVES slaves that share the request
// lines and each own one PSEL bit.
// Ports:
//   PCLK   : clock
//   PRESET : asynchronous active-high reset
//   bus    : apb_cmd_master_if.master (command, response and APB signals)
// Timing (no wait states): accept N, SETUP N+1, ACCESS N+2, rsp_valid N+3.
// An out-of-range slave index skips the bus and responds on N+1 with error.
// -----------------------------------------------------------------------------
module apb_cmd_master
    import apb_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int NUM_SLAVES     = DEF_NUM_SLAVES,
    parameter int SLV_IDX_WIDTH  = DEF_SLV_IDX_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             PCLK,
    input  logic             PRESET,
    apb_cmd_master_if.master bus
);

    // One extra bit so NUM_SLAVES itself is representable for the range check.
    localparam logic [SLV_IDX_WIDTH:0] NUM_SLV_EXT = (SLV_IDX_WIDTH + 1)'(NUM_SLAVES);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [SLV_IDX_WIDTH-1:0] r_slv;
    logic                     r_write;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH-1:0]    r_rsp_rdata;
    logic                     r_rsp_err;
    logic                     r_rsp_timeout;

    logic                     w_cmd_ready;
    logic                     w_accept;
    logic                     w_slv_ok;
    logic                     w_load_cmd;
    logic                     w_rsp_load;
    logic                     w_rsp_err_nxt;
    logic                     w_rsp_tmo_nxt;
    logic [DATA_WIDTH-1:0]    w_rsp_rdata_nxt;
    logic                     w_tmr_en;
    logic                     w_expired;
    logic [NUM_SLAVES-1:0]    w_psel_dec;

    assign w_cmd_ready = (r_state == IDLE) || (r_state == RESP);
    assign w_accept    = bus.cmd_valid && w_cmd_ready;
    assign w_slv_ok    = ({1'b0, bus.cmd_slv} < NUM_SLV_EXT);
    assign w_tmr_en    = (r_state == ACCESS) && !bus.PREADY;

    apb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .i_clk     (PCLK),
        .i_rst     (PRESET),
        .i_clr     (w_load_cmd),
        .i_en      (w_tmr_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_load_cmd      = 1'b0;
        w_rsp_load      = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_tmo_nxt   = 1'b0;
        w_rsp_rdata_nxt = '0;
        case (r_state)
            IDLE, RESP: begin
                w_state_nxt = IDLE;
                if (w_accept) begin
                    if (w_slv_ok) begin
                        w_state_nxt = SETUP;
                        w_load_cmd  = 1'b1;
                    end else begin
                        // Unknown slave: answer straight away, bus untouched.
                        w_state_nxt   = RESP;
                        w_rsp_load    = 1'b1;
                        w_rsp_err_nxt = 1'b1;
                    end
                end
            end
            SETUP: begin
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                // PREADY wins over expiry on the limit cycle.
                if (bus.PREADY) begin
                    w_state_nxt     = RESP;
                    w_rsp_load      = 1'b1;
                    w_rsp_err_nxt   = bus.PSLVERR;
                    w_rsp_rdata_nxt = (!r_write && !bus.PSLVERR) ? bus.PRDATA : '0;
                end else if (w_expired) begin
                    w_state_nxt   = RESP;
                    w_rsp_load    = 1'b1;
                    w_rsp_err_nxt = 1'b1;
                    w_rsp_tmo_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request fields stay at their last values outside a transfer; the
    // response fields hold until the next completion.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_slv         <= '0;
            r_write       <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_load_cmd) begin
                r_slv   <= bus.cmd_slv;
                r_write <= bus.cmd_write;
                r_addr  <= bus.cmd_addr;
                r_wdata <= bus.cmd_wdata;
            end
            if (w_rsp_load) begin
                r_rsp_rdata   <= w_rsp_rdata_nxt;
                r_rsp_err     <= w_rsp_err_nxt;
                r_rsp_timeout <= w_rsp_tmo_nxt;
            end
        end
    end

    always_comb begin
        w_psel_dec = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_psel_dec[i] = (r_slv == SLV_IDX_WIDTH'(i));
        end
    end

    // PSEL/PENABLE decode straight from the state register so an async reset
    // removes them without waiting for a clock edge.
    assign bus.PSEL        = ((r_state == SETUP) || (r_state == ACCESS)) ? w_psel_dec : '0;
    assign bus.PENABLE     = (r_state == ACCESS);
    assign bus.PWRITE      = r_write;
    assign bus.PADDR       = r_addr;
    assign bus.PWDATA      = r_wdata;
    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.rsp_valid   = (r_state == RESP);
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_apb_cmd_master
// Scoreboard bench for apb_cmd_master: each accepted command pushes its
// expected response (data, flags, completion cycle, bus activity); a monitor
// pops and compares on every rsp_valid.
// -----------------------------------------------------------------------------
module tb_apb_cmd_master;
    import apb_cmd_pkg::*;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int NS = 2;
    localparam int SW = 4;
    localparam int TO = 16;

    typedef struct {
        int            cyc;
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
        logic [NS-1:0] psel;
        int            psel_n;
        int            pen_n;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } exp_t;

    logic PCLK;
    logic PRESET;

    apb_cmd_master_if #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SLV_IDX_WIDTH(SW)
    ) bus ();

    apb_cmd_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS),
        .SLV_IDX_WIDTH(SW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    exp_t    sb[$];
    int      n_checks = 0;
    int      n_fail   = 0;
    int      cyc      = 0;
    int      proto_err = 0;
    int      sl_wait  = 0;
    logic [DW-1:0] sl_rdata = '0;
    logic    sl_err   = 1'b0;

    int            mon_psel_n = 0;
    int            mon_pen_n  = 0;
    logic [NS-1:0] mon_psel_or = '0;
    logic [AW-1:0] mon_addr = '0;
    logic          mon_wr   = 1'b0;
    logic [DW-1:0] mon_wdata = '0;

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        forever begin
            @(posedge PCLK);
            cyc++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // APB slave model: PREADY low for sl_wait ACCESS cycles, then high.
    initial begin
        int acc_cnt;
        acc_cnt     = 0;
        bus.PREADY  = 1'b1;
        bus.PRDATA  = '0;
        bus.PSLVERR = 1'b0;
        forever begin
            @(negedge PCLK);
            bus.PRDATA  = sl_rdata;
            bus.PSLVERR = sl_err;
            if (bus.PENABLE && (bus.PSEL != '0)) begin
                acc_cnt++;
                bus.PREADY = (acc_cnt > sl_wait);
            end else begin
                acc_cnt    = 0;
                bus.PREADY = 1'b1;
            end
        end
    end

    // Monitor: bus protocol bookkeeping and scoreboard compare on responses.
    initial begin
        exp_t e;
        forever begin
            @(negedge PCLK);
            if (PRESET) begin
                mon_psel_n  = 0;
                mon_pen_n   = 0;
                mon_psel_or = '0;
            end else begin
                if ($countones(bus.PSEL) > 1) proto_err++;
                if (bus.PENABLE && (bus.PSEL == '0)) proto_err++;
                if (bus.PSEL != '0) begin
                    if (mon_psel_n == 0) begin
                        mon_addr  = bus.PADDR;
                        mon_wr    = bus.PWRITE;
                        mon_wdata = bus.PWDATA;
                    end else if ((bus.PADDR != mon_addr) || (bus.PWRITE != mon_wr) ||
                                 (bus.PWDATA != mon_wdata)) begin
                        proto_err++;
                    end
                    mon_psel_n++;
                    mon_psel_or = mon_psel_or | bus.PSEL;
                    if (bus.PENABLE) mon_pen_n++;
                end
                if (bus.rsp_valid) begin
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_cycle",   cyc, e.cyc);
                        chk("rsp_rdata",   bus.rsp_rdata, e.rdata);
                        chk("rsp_err",     bus.rsp_err, e.err);
                        chk("rsp_timeout", bus.rsp_timeout, e.tmo);
                        chk("psel_value",  mon_psel_or, e.psel);
                        chk("psel_cycles", mon_psel_n, e.psel_n);
                        chk("pen_cycles",  mon_pen_n, e.pen_n);
                        chk("bus_idle_in_resp", {bus.PSEL, bus.PENABLE}, 0);
                        if (e.psel != '0) begin
                            chk("paddr",  mon_addr, e.addr);
                            chk("pwrite", mon_wr, e.wr);
                            if (e.wr) chk("pwdata", mon_wdata, e.wdata);
                        end
                    end
                    mon_psel_n  = 0;
                    mon_pen_n   = 0;
                    mon_psel_or = '0;
                end
            end
        end
    end

    // Present one command and push its expected response once accepted.
    task automatic send(input logic wr, input logic [SW-1:0] slv, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input int wait_n, input logic [DW-1:0] rd,
                        input logic serr, input bit hold, output int acc);
        exp_t e;
        bit   ok;
        bit   tmo;
        bit   got;
        int   n_acc;
        sl_wait  = wait_n;
        sl_rdata = rd;
        sl_err   = serr;
        bus.cmd_write = wr;
        bus.cmd_slv   = slv;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        bus.cmd_valid = 1'b1;
        ok      = (int'(slv) < NS);
        tmo     = ok && (TO != 0) && (wait_n >= TO);
        n_acc   = tmo ? TO : wait_n + 1;
        e.err   = !ok || tmo || serr;
        e.tmo   = tmo;
        e.rdata = (ok && !tmo && !wr && !serr) ? rd : '0;
        e.psel  = ok ? (NS'(1) << slv) : '0;
        e.psel_n = ok ? n_acc + 1 : 0;
        e.pen_n  = ok ? n_acc : 0;
        e.wr    = wr;
        e.addr  = addr;
        e.wdata = wd;
        e.cyc   = 0;
        acc = -1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge PCLK);
            if (bus.cmd_ready) begin
                got   = 1'b1;
                acc   = cyc;
                e.cyc = cyc + (ok ? n_acc + 2 : 1);
                sb.push_back(e);
            end
        end
        if (!got) chk("accept_timeout", 0, 1);
        @(posedge PCLK);
        #1;
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0) && (n < 100)) begin
            @(posedge PCLK);
            n++;
        end
        @(posedge PCLK);
        #1;
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        sl_err = 1'b0;
    endtask

    initial begin
        int a1;
        int a2;
        logic [DW-1:0] st;

        PRESET        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_slv   = '0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        repeat (2) @(posedge PCLK);
        #1;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_psel",      bus.PSEL, 0);
        chk("rst_penable",   bus.PENABLE, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_err",   bus.rsp_err, 0);
        chk("rst_paddr",     bus.PADDR, 0);
        #2 PRESET = 1'b0;
        @(posedge PCLK);
        #1;

        // Zero-wait write to slave 0 CTRL1
        send(1'b1, 4'd0, UART_CTRL1, 8'h1A, 0, 8'hEE, 1'b0, 1'b0, a1);
        drain();

        // Read slave 1 STATUS with four wait states
        st = '0;
        st[STAT_TXRDY] = 1'b1;
        st[STAT_RXRDY] = 1'b1;
        send(1'b0, 4'd1, UART_STATUS, 8'h00, 4, st, 1'b0, 1'b0, a1);
        drain();

        // Back-to-back with cmd_valid held
        send(1'b1, 4'd0, UART_TXDATA, 8'h55, 0, 8'hA5, 1'b0, 1'b1, a1);
        send(1'b0, 4'd1, UART_RXDATA, 8'h00, 0, 8'hA5, 1'b0, 1'b0, a2);
        chk("b2b_accept_gap", a2 - a1, 3);
        drain();

        // PREADY never returns: timeout after 16 ACCESS cycles
        send(1'b0, 4'd0, UART_CTRL2, 8'h00, 1000, 8'h5A, 1'b0, 1'b0, a1);
        drain();

        // PREADY on the 16th ACCESS cycle: normal completion
        st = '0;
        st[STAT_PARITY_ERR] = 1'b1;
        st[STAT_OVERFLOW]   = 1'b1;
        send(1'b0, 4'd1, UART_STATUS, 8'h00, 15, st, 1'b0, 1'b0, a1);
        drain();

        // Out-of-range slave index
        send(1'b1, 4'd3, UART_TXDATA, 8'h99, 0, 8'h00, 1'b0, 1'b0, a1);
        drain();

        // Slave error on a read
        send(1'b0, 4'd1, UART_CTRL2, 8'h00, 0, 8'h77, 1'b1, 1'b0, a1);
        drain();

        // Reset in the middle of ACCESS
        send(1'b0, 4'd0, UART_CTRL1, 8'h00, 1000, 8'h42, 1'b0, 1'b0, a1);
        @(posedge PCLK);
        #3;
        chk("pre_rst_penable", bus.PENABLE, 1);
        PRESET = 1'b1;
        #1;
        chk("midrst_psel",      bus.PSEL, 0);
        chk("midrst_penable",   bus.PENABLE, 0);
        chk("midrst_cmd_ready", bus.cmd_ready, 1);
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        if (sb.size() != 0) void'(sb.pop_back());
        repeat (2) @(posedge PCLK);
        #3 PRESET = 1'b0;
        repeat (6) @(posedge PCLK);
        #1;
        chk("postrst_cmd_ready", bus.cmd_ready, 1);

        // Recovery transfer after reset
        send(1'b1, 4'd1, UART_TXDATA, 8'h3C, 2, 8'h00, 1'b0, 1'b0, a1);
        drain();

        chk("protocol_violations", proto_err, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- Hardware APB initiator that converts a simple command/response handshake into APB3 read/write transfers.
- Lets fabric logic (sequencers, loopback checkers) program and poll CoreUARTapb instances without a CPU.
- Sits between a local control FSM and up to NUM_SLAVES APB slaves that share PADDR/PWDATA/PENABLE/PWRITE and have one PSEL bit each.
- PRDATA/PREADY/PSLVERR are already muxed externally by PSEL.

Parameters:
- ADDR_WIDTH, 5, PADDR width (CoreUARTapb register space).
- DATA_WIDTH, 8, PWDATA/PRDATA width.
- NUM_SLAVES, 2, number of PSEL outputs; legal range 1..16.
- SLV_IDX_WIDTH, 4, width of cmd_slv.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables timeout.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_slv  in  SLV_IDX_WIDTH  target slave index.
- cmd_addr  in  ADDR_WIDTH  register address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  PSLVERR, timeout, or bad slave index.
- rsp_timeout  out  1  abort was caused by timeout.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  read data from the selected slave.
- PREADY  in  1  slave ready; tie to 1 for slaves without wait states.
- PSLVERR  in  1  slave error.

Behaviour:
- Reset (async, PRESET=1): state IDLE; all outputs 0 except cmd_ready=1. Asserting reset mid-transfer drops PSEL/PENABLE immediately; no response is issued.
- States: IDLE, SETUP, ACCESS, RESP.
- cmd_ready=1 only in IDLE and RESP. A command is accepted on a cycle where cmd_valid && cmd_ready.
- Acceptance with cmd_slv < NUM_SLAVES:
  - latch write/addr/wdata; go to SETUP;
  - in SETUP: PSEL[cmd_slv]=1, PENABLE=0, PADDR/PWRITE/PWDATA valid.
- Acceptance with cmd_slv >= NUM_SLAVES: no bus activity; go to RESP with rsp_err=1, rsp_timeout=0.
- SETUP -> ACCESS unconditionally after one cycle. In ACCESS: PENABLE=1, PSEL unchanged.
- ACCESS with PREADY=1:
  - go to RESP;
  - rsp_err=PSLVERR;
  - rsp_rdata=PRDATA if read and PSLVERR=0, else 0;
  - PSEL/PENABLE drop in RESP.
- ACCESS with PREADY=0: wait counter increments.
  - If TIMEOUT_CYCLES != 0 and counter reaches TIMEOUT_CYCLES, go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY=1 on the same cycle the counter reaches its limit counts as completion; it is not a timeout.
- RESP: rsp_valid=1 for exactly one cycle. If a new command is accepted in RESP, go to SETUP; otherwise go to IDLE.
- rsp_* fields hold their value until the next response. There is no response backpressure.
- Latency and throughput:
  - accept on cycle N -> SETUP N+1 -> ACCESS N+2 -> rsp_valid N+3 (zero wait states);
  - back-to-back throughput is one transfer per 3 cycles;
  - each PREADY=0 cycle adds one cycle.
- PADDR/PWRITE/PWDATA stay stable from SETUP through the last ACCESS cycle. They keep their last values in IDLE/RESP and are not forced to 0.
- The wait counter is cleared on entry to SETUP. Its width is clog2(TIMEOUT_CYCLES+1), minimum 1. It saturates and never wraps.
- PSEL is never multi-hot. PENABLE is never high without PSEL.

Decomposition:
- Shared package apb_cmd_pkg:
  - state enum (IDLE, SETUP, ACCESS, RESP);
  - default width constants;
  - CoreUARTapb register offsets: TXDATA=0x00, RXDATA=0x04, CTRL1=0x08, CTRL2=0x0C, STATUS=0x10;
  - STATUS bit positions: TXRDY=0, RXRDY=1, PARITY_ERR=2, OVERFLOW=3.
- One sub-module, apb_wait_timer: saturating counter with clear/enable/expired, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Write to slave 0 (CTRL1=0x08, data 0x1A) with PREADY=1.
  - Required: PSEL=2'b01 for exactly 2 cycles, PENABLE only on the 2nd, PWRITE=1;
  - rsp_valid 3 cycles after acceptance; rsp_err=0; rsp_rdata=0.
- Read slave 1 STATUS (0x10) with PRDATA=0x03 and PREADY low for 4 ACCESS cycles.
  - Required: PSEL=2'b10 for 6 cycles; rsp_rdata=0x03; rsp_valid 7 cycles after acceptance.
- Back-to-back: write 0x55 to TXDATA on slave 0, then read RXDATA on slave 1, with cmd_valid held continuously.
  - Required: second SETUP directly follows the RESP cycle; 6 cycles total; PSEL never 2'b11.
- Hold PREADY=0 with TIMEOUT_CYCLES=16.
  - Required: abort after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0; PSEL=0 in RESP.
  - Repeat with PREADY=1 on the 16th cycle: normal completion, rsp_timeout=0.
- Apply the following error and reset cases:
  - cmd_slv=3 with NUM_SLAVES=2: no PSEL activity; rsp_valid the next cycle with rsp_err=1.
  - PSLVERR=1 on a read: rsp_err=1, rsp_rdata=0.
  - PRESET asserted mid-ACCESS: PSEL/PENABLE go to 0 asynchronously, cmd_ready=1, no rsp_valid.
